stopwatch_ctrl: RTL and testbench

- Control/sequencing block for the stopwatch datapath, a chain of single-digit BCD watch counters.
- Turns start_resume, stop and lap button levels into a run/pause/clear state machine.
- Generates the prescaled count-enable tick that advances the least-significant digit.
- Freezes the display on lap and halts when the most-significant digit overflows.

---
 rtl/stopwatch_ctrl_pkg.sv | 17 +
 rtl/stopwatch_ctrl_tick_divider.sv | 32 +++
 rtl/stopwatch_ctrl.sv | 101 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control path and display mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_FULL  = 2'b11
  } sw_state_t;

  // Simulation-friendly default; the board build overrides with the real prescale.
  localparam int TICK_DIV_DEFAULT = 4;
  localparam int PW_DEFAULT       = 24;

endpackage

// File: rtl/stopwatch_ctrl_tick_divider.sv
// Prescaler producing one count tick every TICK_DIV enabled cycles.
// Latency: tick is combinational from the counter; first tick TICK_DIV enabled cycles after a clear.
// Backpressure: none; while en is low the counter holds so a partial period survives a pause.
module tick_divider #(
  parameter int TICK_DIV = 4,
  parameter int PW       = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  // Count 0..TICK_DIV-1 while enabled, hold otherwise; clr wins over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the BCD stopwatch digit chain, plus lap freeze and overflow halt.
// Latency: state/clear/lap_hold change one cycle after the button edge; count_en is combinational.
// Backpressure: none; ovf from the top digit forces FULL, which stops ticks until cleared.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int PW       = PW_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       lap,
  input  logic       ovf,
  output logic       count_en,
  output logic       clear,
  output logic       lap_hold,
  output logic [1:0] state
);

  sw_state_t st;
  logic      start_prev;
  logic      stop_prev;
  logic      lap_prev;
  logic      start_edge;
  logic      stop_edge;
  logic      lap_edge;
  logic      clear_req;

  // Remember last button levels so a held button yields a single edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      lap_prev   <= 1'b0;
    end else begin
      start_prev <= start_resume;
      stop_prev  <= stop;
      lap_prev   <= lap;
    end
  end

  assign start_edge = start_resume & ~start_prev;
  assign stop_edge  = stop & ~stop_prev;
  assign lap_edge   = lap & ~lap_prev;

  // A stop edge clears everywhere except RUN, where it only pauses.
  assign clear_req  = stop_edge & (st != ST_RUN);

  // Sequencer with registered state, clear pulse and lap freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= ST_IDLE;
      clear    <= 1'b0;
      lap_hold <= 1'b0;
    end else begin
      clear <= clear_req;

      case (st)
        ST_IDLE: begin
          if (!stop_edge && start_edge) st <= ST_RUN;
        end
        ST_RUN: begin
          if (stop_edge)  st <= ST_PAUSE;
          else if (ovf)   st <= ST_FULL;
        end
        ST_PAUSE: begin
          if (stop_edge)       st <= ST_IDLE;
          else if (start_edge) st <= ST_RUN;
        end
        ST_FULL: begin
          if (stop_edge) st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase

      // Lap toggles the freeze while running and releases it when stopped.
      if (clear_req) begin
        lap_hold <= 1'b0;
      end else if (lap_edge) begin
        if (st == ST_RUN)       lap_hold <= ~lap_hold;
        else if (st != ST_IDLE) lap_hold <= 1'b0;
      end
    end
  end

  assign state = st;

  tick_divider #(
    .TICK_DIV (TICK_DIV),
    .PW       (PW)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .en    (st == ST_RUN),
    .clr   (clear_req),
    .tick  (count_en)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int TD      = 4;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_FULL  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_resume;
  logic       stop;
  logic       lap;
  logic       ovf;
  logic       count_en;
  logic       clear;
  logic       lap_hold;
  logic [1:0] state;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  stopwatch_ctrl #(.TICK_DIV(TD), .PW(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_resume (start_resume),
    .stop         (stop),
    .lap          (lap),
    .ovf          (ovf),
    .count_en     (count_en),
    .clear        (clear),
    .lap_hold     (lap_hold),
    .state        (state)
  );

  always #10 clk = ~clk;

  // Abstract model: state number, fractional prescaler phase, pulses, last button levels.
  typedef struct packed {
    int st;
    int pre;
    bit clr;
    bit lap;
    bit ps;
    bit pp;
    bit pl;
  } model_t;

  model_t m;

  function automatic model_t step_model(model_t c, bit s, bit p, bit l, bit o);
    model_t n;
    bit se, pe, le, do_clr;
    n      = c;
    se     = s && !c.ps;
    pe     = p && !c.pp;
    le     = l && !c.pl;
    do_clr = 1'b0;
    n.ps   = s;
    n.pp   = p;
    n.pl   = l;
    if (c.st == S_RUN) n.pre = (c.pre + 1) % TD;
    case (c.st)
      S_IDLE:  if (pe) do_clr = 1'b1; else if (se) n.st = S_RUN;
      S_RUN:   if (pe) n.st = S_PAUSE; else if (o) n.st = S_FULL;
      S_PAUSE: if (pe) begin n.st = S_IDLE; do_clr = 1'b1; end else if (se) n.st = S_RUN;
      default: if (pe) begin n.st = S_IDLE; do_clr = 1'b1; end
    endcase
    if (do_clr) begin
      n.pre = 0;
      n.lap = 1'b0;
    end else if (le) begin
      if (c.st == S_RUN)       n.lap = !c.lap;
      else if (c.st != S_IDLE) n.lap = 1'b0;
    end
    n.clr = do_clr;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step_model(m, start_resume, stop, lap, ovf);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_state",    int'(state),    m.st);
      chk("cyc_count_en", int'(count_en), int'(m.st == S_RUN && m.pre == TD - 1));
      chk("cyc_clear",    int'(clear),    int'(m.clr));
      chk("cyc_lap_hold", int'(lap_hold), int'(m.lap));
    end
  end

  task automatic drive(input bit s, input bit p, input bit l, input bit o);
    start_resume = s;
    stop         = p;
    lap          = l;
    ovf          = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int        n;
    bit [11:0] seen12;
    bit [3:0]  seen4;

    reset = 1'b1; start_resume = 0; stop = 0; lap = 0; ovf = 0;
    #5;
    chk("reset_outputs", int'({state, count_en, clear, lap_hold}), 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    reset  = 1'b0;
    chk_on = 1'b1;

    // 1: idle with buttons low
    n = 0;
    repeat (20) begin n += int'(count_en); drive(0, 0, 0, 0); end
    chk("idle_no_ticks", n, 0);
    chk("idle_state", int'(state), S_IDLE);

    // 2: start and run
    drive(1, 0, 0, 0);
    chk("start_to_run", int'(state), S_RUN);
    for (int k = 0; k < 12; k++) begin
      seen12[k] = count_en;
      drive(1, 0, 0, 0);
    end
    chk("run_tick_pattern", int'(seen12), 'h888);

    // 3: pause two cycles after a tick, then resume
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    chk("stop_to_pause", int'(state), S_PAUSE);
    n = 0;
    repeat (10) begin n += int'(count_en); drive(0, 1, 0, 0); end
    chk("pause_no_ticks", n, 0);
    drive(1, 0, 0, 0);
    chk("resume_state", int'(state), S_RUN);
    chk("resume_c1_no_tick", int'(count_en), 0);
    drive(1, 0, 0, 0);
    chk("resume_c2_tick", int'(count_en), 1);

    // 4: clear from pause
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    chk("clear_state_idle", int'(state), S_IDLE);
    chk("clear_pulse_hi", int'(clear), 1);
    drive(0, 0, 0, 0);
    chk("clear_pulse_lo", int'(clear), 0);
    drive(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      seen4[k] = count_en;
      drive(0, 0, 0, 0);
    end
    chk("post_clear_first_tick", int'(seen4), 'b1000);

    // asynchronous reset mid-run
    drive(0, 0, 1, 0);
    chk("lap_before_reset", int'(lap_hold), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'({state, count_en, clear, lap_hold}), 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0);
    chk("after_reset_idle", int'(state), S_IDLE);

    // 5: overflow
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("ovf_to_full", int'(state), S_FULL);
    n = 0;
    repeat (8) begin n += int'(count_en); drive(0, 0, 0, 0); end
    chk("full_no_ticks", n, 0);
    drive(1, 0, 0, 0);
    chk("full_ignores_start", int'(state), S_FULL);
    drive(0, 1, 0, 0);
    chk("full_stop_idle", int'(state), S_IDLE);
    chk("full_stop_clear", int'(clear), 1);

    // 6: simultaneous events and lap
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("sim_run", int'(state), S_RUN);
    drive(0, 0, 0, 0);
    drive(1, 1, 0, 0);
    chk("stop_beats_start", int'(state), S_PAUSE);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 1);
    chk("stop_beats_ovf", int'(state), S_PAUSE);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk("lap_set", int'(lap_hold), 1);
    n = 0;
    repeat (8) begin n += int'(count_en); drive(0, 0, 0, 0); end
    chk("lap_ticks_continue", n, 2);
    drive(0, 0, 1, 0);
    chk("lap_toggle_off", int'(lap_hold), 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk("idle_lap_state", int'(state), S_IDLE);
    chk("idle_lap_ignored", int'(lap_hold), 0);

    // randomized levels, checked by the per-cycle compare
    repeat (2000) begin
      drive(($urandom_range(0, 3) == 0) ? !start_resume : start_resume,
            ($urandom_range(0, 5) == 0) ? !stop : stop,
            ($urandom_range(0, 3) == 0) ? !lap : lap,
            ($urandom_range(0, 39) == 0));
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
